// File: rtl/genesis_multipad_reader.sv
// Polls NUM_PADS Genesis/Mega Drive DB9 pads once per vga_vs falling edge through an
// 8-phase Select sequence, then commits button words, presence and six-button flags together.
module genesis_multipad_reader #(
    parameter int NUM_PADS     = 2,
    parameter int PHASE_CYCLES = 1000
) (
    input  logic                    clock_50,
    input  logic                    reset,
    input  logic                    vga_vs,
    input  logic [6*NUM_PADS-1:0]   pad_pins,
    output logic                    pad_select,
    output logic [12*NUM_PADS-1:0]  buttons,
    output logic [12*NUM_PADS-1:0]  pressed,
    output logic [NUM_PADS-1:0]     pad_present,
    output logic [NUM_PADS-1:0]     pad_six,
    output logic                    frame_valid,
    output logic                    busy
);
    localparam int CW = $clog2(PHASE_CYCLES);

    typedef enum logic {IDLE, POLL} state_t;

    state_t                  state, state_next;
    logic [2:0]              phase, phase_next;
    logic [CW-1:0]           cyc, cyc_next;
    logic                    sel_next;
    logic                    commit;
    logic                    last_cycle;
    logic [2:0]              vs_sync;
    logic                    vs_fall;
    logic [6*NUM_PADS-1:0]   pins_meta, pins_sync;
    logic [12*NUM_PADS-1:0]  shadow_btn;
    logic [NUM_PADS-1:0]     shadow_present, shadow_six;
    logic [12*NUM_PADS-1:0]  commit_btn;
    logic [NUM_PADS-1:0]     commit_six;

    assign last_cycle = (cyc == CW'(PHASE_CYCLES - 1));
    assign busy       = (state == POLL);

    // The falling-edge pulse is registered once more so the FSM only sees clean, synchronised events.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            vs_sync   <= '0;
            vs_fall   <= 1'b0;
            pins_meta <= '0;
            pins_sync <= '0;
        end else begin
            vs_sync   <= {vs_sync[1:0], vga_vs};
            vs_fall   <= vs_sync[2] & ~vs_sync[1];
            pins_meta <= pad_pins;
            pins_sync <= pins_meta;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = phase;
        cyc_next   = cyc;
        sel_next   = pad_select;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                sel_next = 1'b1;
                if (vs_fall) begin
                    state_next = POLL;
                    phase_next = 3'd0;
                    cyc_next   = '0;
                end
            end
            POLL: begin
                if (last_cycle) begin
                    cyc_next   = '0;
                    phase_next = phase + 3'd1;
                    // Next phase k+1 is even (Select high) exactly when the current phase is odd.
                    sel_next   = phase[0];
                    if (phase == 3'd7) begin
                        state_next = IDLE;
                        commit     = 1'b1;
                        sel_next   = 1'b1;
                    end
                end else begin
                    cyc_next = cyc + CW'(1);
                end
            end
        endcase
    end

    // Absent pads read as all-zero; three-button pads never report X/Y/Z/Mode.
    always_comb begin
        commit_btn = shadow_btn;
        commit_six = shadow_six & shadow_present;
        for (int n = 0; n < NUM_PADS; n++) begin
            if (!shadow_present[n]) begin
                commit_btn[12*n +: 12] = '0;
            end else if (!shadow_six[n]) begin
                commit_btn[12*n+8 +: 4] = '0;
            end
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state          <= IDLE;
            phase          <= 3'd0;
            cyc            <= '0;
            pad_select     <= 1'b1;
            shadow_btn     <= '0;
            shadow_present <= '0;
            shadow_six     <= '0;
            buttons        <= '0;
            pressed        <= '0;
            pad_present    <= '0;
            pad_six        <= '0;
            frame_valid    <= 1'b0;
        end else begin
            state       <= state_next;
            phase       <= phase_next;
            cyc         <= cyc_next;
            pad_select  <= sel_next;
            frame_valid <= commit;
            pressed     <= '0;
            if (state == POLL && last_cycle) begin
                for (int n = 0; n < NUM_PADS; n++) begin
                    case (phase)
                        3'd1: begin
                            shadow_btn[12*n+4]  <= ~pins_sync[6*n+4];
                            shadow_btn[12*n+7]  <= ~pins_sync[6*n+5];
                            shadow_present[n]   <= ~pins_sync[6*n+2] & ~pins_sync[6*n+3];
                        end
                        3'd2: begin
                            shadow_btn[12*n +: 4] <= ~pins_sync[6*n +: 4];
                            shadow_btn[12*n+5]    <= ~pins_sync[6*n+4];
                            shadow_btn[12*n+6]    <= ~pins_sync[6*n+5];
                        end
                        3'd5: begin
                            shadow_six[n] <= shadow_present[n] & (pins_sync[6*n +: 4] == 4'b0000);
                        end
                        3'd6: begin
                            shadow_btn[12*n+10] <= ~pins_sync[6*n+0];
                            shadow_btn[12*n+9]  <= ~pins_sync[6*n+1];
                            shadow_btn[12*n+8]  <= ~pins_sync[6*n+2];
                            shadow_btn[12*n+11] <= ~pins_sync[6*n+3];
                        end
                        default: ;
                    endcase
                end
            end
            if (commit) begin
                buttons     <= commit_btn;
                pressed     <= commit_btn & ~buttons;
                pad_present <= shadow_present;
                pad_six     <= commit_six;
            end
        end
    end
endmodule
